// File: rtl/riscv_bus_pkg.sv
// Shared definitions for the CPU data-memory bus responder.
// Contents: bus widths, MMIO register offsets, STATUS bit indices, UART TX state encoding.
package riscv_bus_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned LANES  = XLEN / 8;
  localparam int unsigned BYTE_W = 8;

  // MMIO register offsets, selected by data_addr[3:2]
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CYCLES = 2'd2;

  // STATUS register bit positions
  localparam int unsigned ST_FULL  = 0;
  localparam int unsigned ST_EMPTY = 1;
  localparam int unsigned ST_BUSY  = 2;
  localparam int unsigned ST_OVF   = 3;
  localparam int unsigned ST_W     = 4;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/dmem_mmio_if.sv
// CPU data-memory bus.
// master: CPU side (drives address, write data, lane enables; receives read data).
// slave:  memory/MMIO responder side.
interface dmem_mmio_if;
  import riscv_bus_pkg::*;

  logic [XLEN-1:0]  data_addr;
  logic [XLEN-1:0]  data_rd;
  logic [XLEN-1:0]  data_wr;
  logic [LANES-1:0] data_wr_en;

  modport master (output data_addr, data_wr, data_wr_en, input data_rd);
  modport slave  (input data_addr, data_wr, data_wr_en, output data_rd);
endinterface

// File: rtl/uart_tx.sv
// UART 8N1 transmitter: FSM, baud down-counter and shift register.
// Ports: clk, rst (sync, active-high); in_valid/in_data/in_ready byte handshake
// (accepted only in IDLE); busy = not IDLE; txd registered serial output, idle high.
module uart_tx
  import riscv_bus_pkg::*;
#(
  parameter int unsigned CLK_DIV = 868
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              txd
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(CLK_DIV - 1);

  uart_state_e       state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [BYTE_W-1:0] shift, shift_nx;
  logic [2:0]        bit_idx, bit_idx_nx;
  logic              txd_nx;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= UART_IDLE;
      cnt     <= '0;
      shift   <= '0;
      bit_idx <= '0;
      txd     <= 1'b1;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      shift   <= shift_nx;
      bit_idx <= bit_idx_nx;
      txd     <= txd_nx;
    end
  end

  // Next state; each non-idle state lasts CLK_DIV cycles
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    shift_nx   = shift;
    bit_idx_nx = bit_idx;
    case (state)
      UART_IDLE: begin
        if (in_valid) begin
          shift_nx = in_data;
          cnt_nx   = CNT_RELOAD;
          state_nx = UART_START;
        end
      end
      UART_START: begin
        if (cnt == '0) begin
          cnt_nx     = CNT_RELOAD;
          bit_idx_nx = 3'd0;
          state_nx   = UART_DATA;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      UART_DATA: begin
        if (cnt == '0) begin
          cnt_nx = CNT_RELOAD;
          if (bit_idx == 3'd7) begin
            state_nx = UART_STOP;
          end else begin
            bit_idx_nx = bit_idx + 3'd1;
            shift_nx   = shift >> 1;
          end
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      UART_STOP: begin
        if (cnt == '0) begin
          state_nx = UART_IDLE;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      default: state_nx = UART_IDLE;
    endcase
  end

  // Line level follows the state being entered so txd can be registered
  always_comb begin
    txd_nx = 1'b1;
    case (state_nx)
      UART_START: txd_nx = 1'b0;
      UART_DATA:  txd_nx = shift_nx[0];
      default:    txd_nx = 1'b1;
    endcase
  end

  assign in_ready = (state == UART_IDLE);
  assign busy     = (state != UART_IDLE);

endmodule

// File: rtl/dmem_mmio.sv
// Data-memory bus responder: byte-lane-writable RAM plus a 16-byte MMIO page
// (UART TXDATA with FIFO, STATUS, free-running CYCLES counter).
// Ports: clk, rst (sync, active-high); bus (dmem_mmio_if.slave, combinational
// data_rd); uart_txd serial output, idle high.
module dmem_mmio
  import riscv_bus_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
  parameter int unsigned CLK_DIV    = 868,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  dmem_mmio_if.slave    bus,
  output logic          uart_txd
);

  localparam int unsigned AW        = $clog2(MEM_WORDS);
  localparam int unsigned PW        = $clog2(FIFO_DEPTH);
  localparam int unsigned RAM_BYTES = 4 * MEM_WORDS;

  logic [XLEN-1:0]   mem [MEM_WORDS];
  logic [BYTE_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW:0]       wr_ptr, rd_ptr;
  logic              ovf;
  logic [XLEN-1:0]   cycles;

  logic              is_ram, is_mmio;
  logic [1:0]        reg_sel;
  logic [AW-1:0]     ram_idx;
  logic              fifo_full, fifo_empty, fifo_valid;
  logic              push_req, push_ok, pop, ovf_clr;
  logic              tx_ready, tx_busy;
  logic [ST_W-1:0]   status;

  // Address decode
  assign is_ram  = bus.data_addr < 32'(RAM_BYTES);
  assign is_mmio = bus.data_addr[31:4] == MMIO_BASE[31:4];
  assign reg_sel = bus.data_addr[3:2];
  assign ram_idx = bus.data_addr[AW+1:2];

  // Extra MSB on the pointers distinguishes full from empty
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign fifo_valid = !fifo_empty;

  assign push_req = is_mmio && (reg_sel == REG_TXDATA) && bus.data_wr_en[0];
  assign push_ok  = push_req && !fifo_full;
  assign pop      = tx_ready && fifo_valid;
  assign ovf_clr  = is_mmio && (reg_sel == REG_STATUS) && bus.data_wr_en[0] && bus.data_wr[ST_OVF];

  // RAM byte-lane writes; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (is_ram) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (bus.data_wr_en[i]) mem[ram_idx][8*i +: 8] <= bus.data_wr[8*i +: 8];
      end
    end
  end

  // FIFO storage; reset only drops entries via the pointers
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr[PW-1:0]] <= bus.data_wr[BYTE_W-1:0];
  end

  // Pointers, sticky overflow (set beats clear), cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
      cycles <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (PW+1)'(1);
      if (push_req && fifo_full) ovf <= 1'b1;
      else if (ovf_clr)          ovf <= 1'b0;
      cycles <= cycles + 32'd1;
    end
  end

  uart_tx #(.CLK_DIV(CLK_DIV)) u_uart_tx (
    .clk      (clk),
    .rst      (rst),
    .in_valid (fifo_valid),
    .in_data  (fifo_mem[rd_ptr[PW-1:0]]),
    .in_ready (tx_ready),
    .busy     (tx_busy),
    .txd      (uart_txd)
  );

  always_comb begin
    status           = '0;
    status[ST_FULL]  = fifo_full;
    status[ST_EMPTY] = fifo_empty;
    status[ST_BUSY]  = tx_busy;
    status[ST_OVF]   = ovf;
  end

  // Combinational read mux: always shows pre-edge state
  always_comb begin
    bus.data_rd = '0;
    if (is_ram) begin
      bus.data_rd = mem[ram_idx];
    end else if (is_mmio) begin
      case (reg_sel)
        REG_STATUS: bus.data_rd = {(XLEN-ST_W)'(0), status};
        REG_CYCLES: bus.data_rd = cycles;
        default:    bus.data_rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: directed scenarios plus random traffic,
// compared against a transaction-level model (word map, byte queue, frame timer).
module tb_dmem_mmio;
  import riscv_bus_pkg::*;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int WORDS = 1024;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic clk = 1'b0;
  logic rst;
  logic txd;

  dmem_mmio_if bus ();

  dmem_mmio #(
    .MEM_WORDS  (WORDS),
    .MMIO_BASE  (BASE),
    .CLK_DIV    (DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .uart_txd (txd)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model
  logic [31:0] m_ram [int];
  byte unsigned m_q [$];
  bit          m_ovf;
  logic [31:0] m_cycles;
  bit          m_active;
  int          m_t;
  logic [7:0]  m_cur;
  bit          m_valid;
  logic [31:0] last_rd;

  // Frame after the pop edge: DIV start, 8*DIV data LSB first, DIV stop
  function automatic bit exp_txd();
    if (!m_active) return 1'b1;
    if (m_t < DIV) return 1'b0;
    if (m_t < 9 * DIV) return m_cur[(m_t - DIV) / DIV];
    return 1'b1;
  endfunction

  function automatic logic [3:0] exp_status();
    return {m_ovf, m_active, m_q.size() == 0, m_q.size() == DEPTH};
  endfunction

  function automatic bit is_mmio_addr(input logic [31:0] a);
    return (a >> 4) == (BASE >> 4);
  endfunction

  function automatic bit exp_rd(input logic [31:0] a, output logic [31:0] v);
    v = 32'h0;
    if (a < 32'(4 * WORDS)) begin
      if (!m_ram.exists(int'(a >> 2))) return 1'b0;
      v = m_ram[int'(a >> 2)];
    end else if (is_mmio_addr(a)) begin
      case (a[3:2])
        2'd1:    v = {28'h0, exp_status()};
        2'd2:    v = m_cycles;
        default: v = 32'h0;
      endcase
    end
    return 1'b1;
  endfunction

  task automatic model_edge(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] en,
                            input logic r);
    int  pre;
    bit  push, clr;
    logic [31:0] w;
    if (r) begin
      m_q.delete();
      m_ovf = 0; m_cycles = 0; m_active = 0; m_t = 0; m_valid = 1;
      return;
    end
    if (!m_valid) return;
    if (a < 32'(4 * WORDS) && en != 4'h0) begin
      if (m_ram.exists(int'(a >> 2)) || en == 4'hF) begin
        w = m_ram.exists(int'(a >> 2)) ? m_ram[int'(a >> 2)] : 32'h0;
        for (int i = 0; i < 4; i++) if (en[i]) w[8*i +: 8] = wd[8*i +: 8];
        m_ram[int'(a >> 2)] = w;
      end
    end
    push = is_mmio_addr(a) && a[3:2] == 2'd0 && en[0];
    clr  = is_mmio_addr(a) && a[3:2] == 2'd1 && en[0] && wd[3];
    pre  = m_q.size();
    if (m_active) begin
      m_t++;
      if (m_t == 10 * DIV) m_active = 0;
    end else if (pre > 0) begin
      m_cur = m_q.pop_front();
      m_active = 1;
      m_t = 0;
    end
    if (push) begin
      if (pre < DEPTH) m_q.push_back(wd[7:0]);
      else m_ovf = 1;
    end
    if (clr && !(push && pre >= DEPTH)) m_ovf = 0;
    m_cycles++;
  endtask

  // One bus cycle: drive, check pre-edge read data and line, then advance model
  task automatic step(input logic [31:0] a, input logic [31:0] wd = 32'h0,
                      input logic [3:0] en = 4'h0, input logic r = 1'b0);
    logic [31:0] v;
    @(negedge clk);
    bus.data_addr  = a;
    bus.data_wr    = wd;
    bus.data_wr_en = en;
    rst            = r;
    #1;
    if (m_valid) begin
      if (exp_rd(a, v)) check_eq($sformatf("rd@%h", a), bus.data_rd, v);
      check_eq("txd", {31'h0, txd}, {31'h0, exp_txd()});
    end
    last_rd = bus.data_rd;
    @(posedge clk);
    model_edge(a, wd, en, r);
  endtask

  function automatic logic [31:0] rnd_ram_addr();
    int idx;
    idx = int'($urandom_range(0, 16));
    return (idx == 16) ? 32'(4 * (WORDS - 1)) : 32'(4 * idx);
  endfunction

  initial begin
    logic [31:0] c0;
    int op;
    rst = 1'b1;
    bus.data_addr = '0; bus.data_wr = '0; bus.data_wr_en = '0;
    m_valid = 0;
    step(32'h0, 32'h0, 4'h0, 1'b1);
    step(32'h0, 32'h0, 4'h0, 1'b1);

    // Reset state
    step(BASE + 32'h8); check_eq("reset_cycles", last_rd, 32'h0);
    step(BASE + 32'h4); check_eq("reset_status", last_rd, 32'h2);
    check_eq("reset_txd", {31'h0, txd}, 32'h1);

    // Initialise the RAM words used by the bench, including the last word
    for (int i = 0; i < 16; i++) step(32'(4 * i), $urandom, 4'hF);
    step(32'(4 * (WORDS - 1)), $urandom, 4'hF);

    // Byte-lane merge
    step(32'h10, 32'hDEADBEEF, 4'hF);
    step(32'h10, 32'h00AA0000, 4'b0100);
    step(32'h10); check_eq("ram_lane", last_rd, 32'hDEAABEEF);

    // Single frame of 0x55
    step(BASE, 32'h55, 4'h1);
    step(BASE + 32'h4); check_eq("pre_pop_status", last_rd, 32'h0);
    step(BASE + 32'h4); check_eq("busy_empty", last_rd, 32'h6);
    repeat (45) step(BASE + 32'h4);

    // FIFO overflow and clear
    for (int i = 0; i < 6; i++) step(BASE, 32'(8'hA0 + i), 4'h1);
    step(BASE + 32'h4); check_eq("ovf_status", last_rd, 32'hD);
    step(BASE + 32'h4, 32'h8, 4'h1);
    step(BASE + 32'h4); check_eq("ovf_cleared", last_rd, 32'h5);
    repeat (5 * (10 * DIV + 1) + 10) step(BASE + 32'h8);

    // Reset during DATA bit 3 with a byte still queued
    step(BASE, 32'h3C, 4'h1);
    step(BASE, 32'hC3, 4'h1);
    repeat (17) step(BASE + 32'h8);
    step(BASE + 32'h8, 32'h0, 4'h0, 1'b1);
    step(BASE + 32'h8); check_eq("rst_cycles", last_rd, 32'h0);
    check_eq("rst_txd", {31'h0, txd}, 32'h1);
    step(BASE + 32'h4); check_eq("rst_status", last_rd, 32'h2);
    repeat (50) step(BASE + 32'h4);

    // Unmapped, reserved, RAM boundary, CYCLES delta
    step(32'h2000_0000, 32'hFFFF_FFFF, 4'hF);
    step(BASE + 32'hC, 32'hFFFF_FFFF, 4'hF);
    step(BASE + 32'h8, 32'hFFFF_FFFF, 4'hF);
    step(BASE + 32'hC); check_eq("reserved_rd", last_rd, 32'h0);
    step(32'h2000_0000); check_eq("unmapped_rd", last_rd, 32'h0);
    step(32'(4 * WORDS)); check_eq("ram_end_rd", last_rd, 32'h0);
    step(BASE + 32'h4); check_eq("decode_status", last_rd, 32'h2);
    step(BASE + 32'h8); c0 = last_rd;
    repeat (4) step(32'h0);
    step(BASE + 32'h8); check_eq("cycles_delta", last_rd - c0, 32'h5);

    // Random traffic
    repeat (700) begin
      op = int'($urandom_range(0, 9));
      if ($urandom_range(0, 249) == 0) step(BASE + 32'h4, 32'h0, 4'h0, 1'b1);
      else case (op)
        0, 1:    step(rnd_ram_addr(), $urandom, 4'(int'($urandom_range(1, 15))));
        2:       step(rnd_ram_addr());
        3, 4:    step(BASE, $urandom, 4'(int'($urandom_range(0, 15))));
        5:       step(BASE + 32'h4, $urandom, 4'(int'($urandom_range(0, 15))));
        6:       step(BASE + 32'h8, $urandom, 4'(int'($urandom_range(0, 15))));
        7:       step(($urandom_range(0, 1) == 0) ? BASE + 32'hC : 32'h2000_0000 + 32'($urandom_range(0, 255)) * 4,
                      $urandom, 4'hF);
        default: step(BASE + 32'h4);
      endcase
    end
    repeat (5 * (10 * DIV + 1) + 5) step(BASE + 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
